// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read, write and issue/scoreboard signals.
// Latency: n/a (wires only).
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// master: the pipeline driving addresses, writes and issues.
// slave : the register file returning read data and scoreboard state.
interface register_file_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_dst;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dst,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dst,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-ported register file with zero register, optional write-to-read bypass and a busy scoreboard.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates land on the rising clk edge.
// Backpressure: none; writes, issues and reads are all accepted every cycle.
//
// Ports: clk, rst (async, active-high), bus (register_file_mp_if.slave):
//   rd_addr/rd_data/rd_busy per read port, wr_en/wr_addr/wr_data per write port,
//   iss_en/iss_dst to mark a destination pending, busy_vec = whole scoreboard.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    register_file_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wr_hit;    // registers targeted by any enabled write this cycle
    logic [NUM_REGS-1:0] iss_mask;  // register being issued this cycle (never r0)
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        wr_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w]) begin
                wr_hit[bus.wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        iss_mask = '0;
        if (bus.iss_en && bus.iss_dst != '0) begin
            iss_mask[bus.iss_dst] = 1'b1;
        end
    end

    // A new issue overrides a completing write to the same register:
    // the newer producer is still outstanding.
    assign busy_nxt = (busy & ~wr_hit) | iss_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            busy <= busy_nxt;
            // Later ports overwrite earlier ones, so the highest port wins on a collision.
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0) begin
                    regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rv;
    logic              rb;
    logic              fwd;

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        rv          = '0;
        rb          = 1'b0;
        fwd         = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra  = bus.rd_addr[p*AW +: AW];
            rv  = regs[ra];
            rb  = busy[ra];
            fwd = 1'b0;
            if (BYPASS != 0) begin
                // Scan in port order so the highest-numbered writer is forwarded,
                // matching what the array will hold after the edge.
                for (int w = 0; w < NUM_WR; w++) begin
                    if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == ra) begin
                        rv  = bus.wr_data[w*DATA_W +: DATA_W];
                        fwd = 1'b1;
                    end
                end
                // Value being forwarded is final unless a newer producer issues now.
                if (fwd && !iss_mask[ra]) begin
                    rb = 1'b0;
                end
            end
            // r0 is hardwired zero and reset masks the bypass path as well.
            if (rst || ra == '0) begin
                rv = '0;
                rb = 1'b0;
            end
            bus.rd_data[p*DATA_W +: DATA_W] = rv;
            bus.rd_busy[p]                  = rb;
        end
    end

    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a 2-write-port bypassing instance (a)
// and a 1-write-port non-bypassing instance (b) share clock and reset.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
module tb_register_file_mp;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    register_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    register_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    register_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus_a.wr_en   = '0;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;
        bus_a.iss_en  = 1'b0;
        bus_a.iss_dst = '0;
        bus_b.wr_en   = '0;
        bus_b.wr_addr = '0;
        bus_b.wr_data = '0;
        bus_b.iss_en  = 1'b0;
        bus_b.iss_dst = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus_a.rd_addr[p*AW +: AW] = a;
        bus_b.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr_a(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_a.wr_en[w]             = 1'b1;
        bus_a.wr_addr[w*AW +: AW]  = a;
        bus_a.wr_data[w*DW +: DW]  = d;
    endtask

    task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_b.wr_en[0]   = 1'b1;
        bus_b.wr_addr    = a;
        bus_b.wr_data    = d;
    endtask

    function automatic logic [DW-1:0] rd_a(input int p);
        return bus_a.rd_data[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rd_b(input int p);
        return bus_b.rd_data[p*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        #3;
        check("in_rst_rd_a0", rd_a(0), 32'h0);
        check("in_rst_busy_a", bus_a.busy_vec, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Every register reads zero on both ports of both instances after reset.
        for (int i = 0; i < NR; i++) begin
            tick();
            set_rd(0, 5'(i));
            set_rd(1, 5'(NR - 1 - i));
            settle();
            check("rst_rd_a0", rd_a(0), 32'h0);
            check("rst_rd_a1", rd_a(1), 32'h0);
            check("rst_rd_b0", rd_b(0), 32'h0);
            check("rst_rd_b1", rd_b(1), 32'h0);
        end
        check("rst_busy_a", bus_a.busy_vec, 32'h0);
        check("rst_busy_b", bus_b.busy_vec, 32'h0);

        // Write x5 with a same-cycle read: bypass vs. no bypass.
        tick();
        wr_a(0, 5'd5, 32'hDEADBEEF);
        wr_b(5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5);
        settle();
        check("byp_x5_a_same", rd_a(0), 32'hDEADBEEF);
        check("nobyp_x5_b_same", rd_b(0), 32'h0);
        tick();
        idle();
        settle();
        check("byp_x5_a_next", rd_a(0), 32'hDEADBEEF);
        check("nobyp_x5_b_next", rd_b(0), 32'hDEADBEEF);

        // Writes to x0 are discarded, including on the bypass path.
        tick();
        wr_a(0, 5'd0, 32'h12345678);
        wr_b(5'd0, 32'h12345678);
        set_rd(1, 5'd0);
        settle();
        check("x0_a_same", rd_a(1), 32'h0);
        check("x0_b_same", rd_b(1), 32'h0);
        tick();
        idle();
        settle();
        check("x0_a_next", rd_a(1), 32'h0);
        check("x0_b_next", rd_b(1), 32'h0);

        // Both write ports to x7: port 1 wins for bypass and storage.
        tick();
        wr_a(0, 5'd7, 32'h11);
        wr_a(1, 5'd7, 32'h22);
        set_rd(0, 5'd7);
        settle();
        check("dual_x7_byp", rd_a(0), 32'h22);
        tick();
        idle();
        settle();
        check("dual_x7_stored", rd_a(0), 32'h22);

        // Independent writes on the two ports in one cycle.
        tick();
        wr_a(0, 5'd6, 32'h44);
        wr_a(1, 5'd8, 32'h33);
        tick();
        idle();
        set_rd(0, 5'd6);
        set_rd(1, 5'd8);
        settle();
        check("dual_x6", rd_a(0), 32'h44);
        check("dual_x8", rd_a(1), 32'h33);

        // Scoreboard on x9.
        tick();
        bus_a.iss_en  = 1'b1;
        bus_a.iss_dst = 5'd9;
        set_rd(0, 5'd9);
        settle();
        check("iss9_busy_same", bus_a.rd_busy[0], 1'b0);
        tick();
        idle();
        settle();
        check("iss9_busy_next", bus_a.rd_busy[0], 1'b1);
        check("iss9_vec", bus_a.busy_vec, 32'h0000_0200);

        tick();
        wr_a(0, 5'd9, 32'h99);
        bus_a.iss_en  = 1'b1;
        bus_a.iss_dst = 5'd9;
        settle();
        check("wr_iss9_busy_same", bus_a.rd_busy[0], 1'b1);
        check("wr_iss9_data_same", rd_a(0), 32'h99);
        tick();
        idle();
        settle();
        check("wr_iss9_busy_next", bus_a.rd_busy[0], 1'b1);
        check("wr_iss9_vec", bus_a.busy_vec, 32'h0000_0200);

        tick();
        wr_a(0, 5'd9, 32'h55);
        settle();
        check("wr9_busy_byp", bus_a.rd_busy[0], 1'b0);
        check("wr9_vec_same", bus_a.busy_vec, 32'h0000_0200);
        tick();
        idle();
        settle();
        check("wr9_busy_next", bus_a.rd_busy[0], 1'b0);
        check("wr9_vec_next", bus_a.busy_vec, 32'h0);
        check("wr9_data", rd_a(0), 32'h55);

        // Issue to x0 has no effect.
        tick();
        bus_a.iss_en  = 1'b1;
        bus_a.iss_dst = 5'd0;
        tick();
        idle();
        settle();
        check("iss0_vec", bus_a.busy_vec, 32'h0);

        // Without bypass the busy flag holds until the write edge.
        tick();
        bus_b.iss_en  = 1'b1;
        bus_b.iss_dst = 5'd9;
        tick();
        idle();
        wr_b(5'd9, 32'h77);
        set_rd(0, 5'd9);
        settle();
        check("b_busy_during_wr", bus_b.rd_busy[0], 1'b1);
        check("b_data_during_wr", rd_b(0), 32'h0);
        tick();
        idle();
        settle();
        check("b_busy_after_wr", bus_b.rd_busy[0], 1'b0);
        check("b_data_after_wr", rd_b(0), 32'h77);

        // Asynchronous reset mid-cycle clears data and scoreboard at once.
        tick();
        wr_a(0, 5'd3, 32'hA5);
        tick();
        idle();
        bus_a.iss_en  = 1'b1;
        bus_a.iss_dst = 5'd3;
        tick();
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd5);
        settle();
        check("pre_rst_x3", rd_a(0), 32'hA5);
        check("pre_rst_vec", bus_a.busy_vec, 32'h0000_0008);
        check("pre_rst_busy", bus_a.rd_busy[0], 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_x3", rd_a(0), 32'h0);
        check("async_rst_vec", bus_a.busy_vec, 32'h0);
        check("async_rst_busy", bus_a.rd_busy[0], 1'b0);
        check("async_rst_x5", rd_a(1), 32'h0);
        wr_a(0, 5'd3, 32'hFF);
        bus_a.iss_en  = 1'b1;
        bus_a.iss_dst = 5'd4;
        #1;
        check("rst_byp_masked", rd_a(0), 32'h0);
        tick();
        idle();
        rst = 1'b0;
        settle();
        check("post_rst_x3", rd_a(0), 32'h0);
        check("post_rst_vec", bus_a.busy_vec, 32'h0);

        // First edge after reset behaves normally.
        tick();
        wr_a(1, 5'd3, 32'h1);
        tick();
        idle();
        settle();
        check("post_rst_wr_x3", rd_a(0), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
